// File: rtl/system_top_sdiv_32s_16s_32_seq.sv
// system_top_sdiv_32s_16s_32_seq
// Sequential signed divider (radix-2 restoring), C semantics: the quotient
// truncates toward zero and the remainder takes the sign of the dividend.
// A divide-by-zero or a most-negative / -1 division saturates the quotient.
// Latency is constant: the accept edge is edge 0 and out_valid rises after
// edge DIN0_WIDTH+2.
// Optional build macro SYSTEM_TOP_SDIV_STATUS_EN adds the dbz/ovf status outputs.
module system_top_sdiv_32s_16s_32_seq #(
    parameter int ID         = 1,
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIN0_WIDTH-1:0] quot,
    output logic [DIN1_WIDTH-1:0] rem
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
    ,
    output logic                  dbz,
    output logic                  ovf
`endif
);

    localparam int CW = $clog2(DIN0_WIDTH + 1);
    localparam logic [DIN0_WIDTH-1:0] QMAX = {1'b0, {(DIN0_WIDTH-1){1'b1}}};
    localparam logic [DIN0_WIDTH-1:0] QMIN = {1'b1, {(DIN0_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [DIN0_WIDTH-1:0]   dvd;      // dividend magnitude, shifted out as quotient bits shift in
    logic [DIN1_WIDTH-1:0]   divs;     // divisor magnitude
    logic [DIN1_WIDTH-1:0]   prem;     // partial remainder, always < divs
    logic                    neg0, neg1, zdiv, sat;

    logic [DIN0_WIDTH-1:0]   abs0;
    logic [DIN1_WIDTH-1:0]   abs1;
    logic [DIN1_WIDTH:0]     shifted;
    logic [DIN1_WIDTH-1:0]   sub;
    logic                    qbit;
    logic                    calc_last;

    // Operand magnitudes and one restoring step on the current partial remainder
    always_comb begin
        abs0    = din0[DIN0_WIDTH-1] ? (~din0 + 1'b1) : din0;
        abs1    = din1[DIN1_WIDTH-1] ? (~din1 + 1'b1) : din1;
        shifted = {prem, dvd[DIN0_WIDTH-1]};
        qbit    = (shifted >= {1'b0, divs});
        sub     = shifted[DIN1_WIDTH-1:0] - divs;
        calc_last = (cnt == CW'(DIN0_WIDTH));
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: if (calc_last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-subtract iterations and sign fix-up.
    // CALC spends one extra cycle after the last step (cnt == DIN0_WIDTH)
    // so the result is presented after edge DIN0_WIDTH+2.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt  <= '0;
            dvd  <= '0;
            divs <= '0;
            prem <= '0;
            neg0 <= 1'b0;
            neg1 <= 1'b0;
            zdiv <= 1'b0;
            sat  <= 1'b0;
            quot <= '0;
            rem  <= '0;
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
            dbz  <= 1'b0;
            ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dvd  <= abs0;
                    divs <= abs1;
                    prem <= '0;
                    cnt  <= '0;
                    neg0 <= din0[DIN0_WIDTH-1];
                    neg1 <= din1[DIN1_WIDTH-1];
                    zdiv <= (din1 == '0);
                    sat  <= (din0 == QMIN) && (din1 == '1);
                end
                CALC: if (!calc_last) begin
                    prem <= qbit ? sub : shifted[DIN1_WIDTH-1:0];
                    dvd  <= {dvd[DIN0_WIDTH-2:0], qbit};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    if (zdiv) begin
                        quot <= neg0 ? QMIN : QMAX;
                        rem  <= '0;
                    end else if (sat) begin
                        quot <= QMAX;
                        rem  <= '0;
                    end else begin
                        quot <= (neg0 ^ neg1) ? (~dvd + 1'b1) : dvd;
                        rem  <= neg0 ? (~prem + 1'b1) : prem;
                    end
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
                    dbz <= zdiv;
                    ovf <= sat & ~zdiv;
`endif
                end
                DONE: begin
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
                    if (out_ready) begin
                        dbz <= 1'b0;
                        ovf <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_system_top_sdiv_32s_16s_32_seq.sv
// Directed bench for system_top_sdiv_32s_16s_32_seq with hand-computed results.
module tb_system_top_sdiv_32s_16s_32_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din0 = '0;
    logic [15:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quot;
    logic [15:0] rem;
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
    logic        dbz, ovf;
`endif

    int checks = 0;
    int errors = 0;

    system_top_sdiv_32s_16s_32_seq #(.ID(1), .DIN0_WIDTH(32), .DIN1_WIDTH(16)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem)
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
        ,
        .dbz       (dbz),
        .ovf       (ovf)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one pair, wait for the result, check latency/values, then take it.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [15:0] b,
                           input logic [31:0] eq, input logic [15:0] er, input int hold);
        int n;
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        din0 = a;
        din1 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        din0 = 'x;
        din1 = 'x;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, n, 32'd34);
        check({tag, ".quot"}, quot, eq);
        check({tag, ".rem"}, {16'b0, rem}, {16'b0, er});
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
        check({tag, ".dbz"}, {31'b0, dbz}, {31'b0, (b == 16'h0)});
        check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, (a == 32'h8000_0000 && b == 16'hFFFF)});
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'b0, in_ready}, 32'd0);
            check({tag, ".hold_quot"}, quot, eq);
            check({tag, ".hold_rem"}, {16'b0, rem}, {16'b0, er});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, ".ready_back"}, {31'b0, in_ready}, 32'd1);
`ifdef SYSTEM_TOP_SDIV_STATUS_EN
        check({tag, ".dbz_clr"}, {31'b0, dbz}, 32'd0);
        check({tag, ".ovf_clr"}, {31'b0, ovf}, 32'd0);
`endif
    endtask

    initial begin
        #2;
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.quot", quot, 32'd0);
        check("rst.rem", {16'b0, rem}, 32'd0);
        #20;
        ap_rst_n = 1'b1;
        tick();

        run_div("p100_7",    32'd100,          16'd7,      32'd14,         16'd2,      0);
        run_div("n100_7",    32'hFFFF_FF9C,    16'd7,      32'hFFFF_FFF2,  16'hFFFE,   0);
        run_div("p100_n7",   32'd100,          16'hFFF9,   32'hFFFF_FFF2,  16'd2,      0);
        run_div("n100_n7",   32'hFFFF_FF9C,    16'hFFF9,   32'd14,         16'hFFFE,   0);
        run_div("min_n1",    32'h8000_0000,    16'hFFFF,   32'h7FFF_FFFF,  16'd0,      0);
        run_div("min_p1",    32'h8000_0000,    16'd1,      32'h8000_0000,  16'd0,      0);
        run_div("min_min16", 32'h8000_0000,    16'h8000,   32'h0001_0000,  16'd0,      0);
        run_div("max_7fff",  32'h7FFF_FFFF,    16'h7FFF,   32'h0001_0002,  16'd1,      0);
        run_div("n5_0",      32'hFFFF_FFFB,    16'd0,      32'h8000_0000,  16'd0,      0);
        run_div("p7_0",      32'd7,            16'd0,      32'h7FFF_FFFF,  16'd0,      0);
        run_div("n3_5",      32'hFFFF_FFFD,    16'd5,      32'd0,          16'hFFFD,   0);
        run_div("hold",      32'd1000,         16'd10,     32'd100,        16'd0,      20);

        // Abort mid-operation with an asynchronous reset
        din0 = 32'd123456;
        din1 = 16'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("abort.busy", {31'b0, in_ready}, 32'd0);
        ap_rst_n = 1'b0;
        #1;
        check("abort.quot", quot, 32'd0);
        check("abort.rem", {16'b0, rem}, 32'd0);
        check("abort.out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        tick();
        #3;
        ap_rst_n = 1'b1;
        tick();
        check("abort.in_ready", {31'b0, in_ready}, 32'd1);
        check("abort.valid_low", {31'b0, out_valid}, 32'd0);
        run_div("after_rst", 32'd9, 16'd2, 32'd4, 16'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
